// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared state type and mode encodings for mux_nx1_scan
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_nx1_scan_ctr.sv
// rtl/mux_nx1_scan_ctr.sv - SCAN dwell counter and channel index with wrap/skip
module scan_ctr #(
    parameter int N_CH  = 4,
    parameter int DWELL = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    input  logic             freeze,
    input  logic [N_CH-1:0]  mask,
    output logic [SEL_W-1:0] cur,
    output logic             strobe
);

    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [SEL_W:0]   N_CH_EXT   = (SEL_W + 1)'(N_CH);

    logic [DW_W-1:0]  dwell;
    logic [SEL_W-1:0] next_ch;
    logic             cur_en;
    logic             all_masked;

    assign cur_en     = mask[cur];
    assign all_masked = (mask == '0);
    assign strobe     = !restart && !freeze && cur_en && (dwell == DWELL_LAST);

    // Next enabled channel after cur, wrapping; may land back on cur itself
    always_comb begin
        logic [SEL_W:0] idx;
        logic           found;
        next_ch = cur;
        idx     = '0;
        found   = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = {1'b0, cur} + (SEL_W + 1)'(i);
            if (idx >= N_CH_EXT) begin
                idx = idx - N_CH_EXT;
            end
            if (!found && mask[idx[SEL_W-1:0]]) begin
                next_ch = idx[SEL_W-1:0];
                found   = 1'b1;
            end
        end
    end

    // Dwell/channel state: restart wins, then freeze/all-masked hold, masked channel skipped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur   <= '0;
            dwell <= '0;
        end else if (restart) begin
            cur   <= '0;
            dwell <= '0;
        end else if (freeze || all_masked) begin
            cur   <= cur;
            dwell <= dwell;
        end else if (!cur_en) begin
            cur   <= next_ch;
            dwell <= '0;
        end else if (dwell == DWELL_LAST) begin
            cur   <= next_ch;
            dwell <= '0;
        end else begin
            dwell <= dwell + 1'b1;
        end
    end

endmodule

// File: rtl/mux_nx1_scan.sv
// rtl/mux_nx1_scan.sv - registered N-channel mux with MANUAL/SCAN modes; optional MUX_SCAN_MASK_EN
module mux_nx1_scan
    import mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_CH  = 4,
    parameter int DWELL = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH*WIDTH-1:0] in_bus,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  out_ready,
`ifdef MUX_SCAN_MASK_EN
    input  logic [N_CH-1:0]       ch_mask,
`endif
    output logic [WIDTH-1:0]      out,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_valid,
    output logic                  sel_err
);

    localparam logic [SEL_W:0]   N_CH_EXT = (SEL_W + 1)'(N_CH);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_CH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] ch_data [N_CH];
    logic [N_CH-1:0]  scan_mask;
    logic [SEL_W-1:0] scan_cur;
    logic             scan_strobe;
    logic             capture_ok;
    logic             accept;
    logic             man_cap;
    logic             scan_cap;
    logic             sel_bad;
    logic [SEL_W-1:0] man_ch;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign ch_data[k] = in_bus[k*WIDTH +: WIDTH];
    end

`ifdef MUX_SCAN_MASK_EN
    assign scan_mask = ch_mask;
`else
    assign scan_mask = '1;
`endif

    assign capture_ok = !out_valid || out_ready;
    assign accept     = out_valid && out_ready;
    assign sel_bad    = ({1'b0, sel} >= N_CH_EXT);
    assign man_ch     = sel_bad ? LAST_CH : sel;
    assign man_cap    = (state == MANUAL) && capture_ok;
    assign scan_cap   = (state == SCAN) && scan_strobe;

    // Counters sit at channel 0 / dwell 0 whenever not scanning, so every SCAN entry restarts
    scan_ctr #(
        .N_CH  (N_CH),
        .DWELL (DWELL)
    ) u_scan_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (state != SCAN),
        .freeze  (!capture_ok),
        .mask    (scan_mask),
        .cur     (scan_cur),
        .strobe  (scan_strobe)
    );

    // Mode state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: enable gates everything, mode picks MANUAL or SCAN
    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else if (mode == MODE_SCAN) begin
            state_nxt = SCAN;
        end else begin
            state_nxt = MANUAL;
        end
    end

    // Output register: capture replaces any sample, else an accepted sample drops valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
        end else if (man_cap) begin
            out       <= ch_data[man_ch];
            out_ch    <= man_ch;
            out_valid <= 1'b1;
            sel_err   <= sel_bad;
        end else if (scan_cap) begin
            out       <= ch_data[scan_cur];
            out_ch    <= scan_cur;
            out_valid <= 1'b1;
            sel_err   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_nx1_scan.sv
// tb/tb_mux_nx1_scan.sv - directed self-checking bench for mux_nx1_scan
module tb_mux_nx1_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] in_bus;
    logic        en, mode, out_ready;
    logic [1:0]  sel;
    logic [7:0]  out;
    logic [1:0]  out_ch;
    logic        out_valid, sel_err;

    logic [23:0] in_bus3;
    logic        en3, mode3, out_ready3;
    logic [1:0]  sel3;
    logic [7:0]  out3;
    logic [1:0]  out_ch3;
    logic        out_valid3, sel_err3;

`ifdef MUX_SCAN_MASK_EN
    logic [3:0]  ch_mask;
    logic [2:0]  ch_mask3;
`endif

    int checks = 0;
    int errors = 0;

    mux_nx1_scan #(.WIDTH(8), .N_CH(4), .DWELL(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .en(en), .mode(mode), .sel(sel),
        .out_ready(out_ready),
`ifdef MUX_SCAN_MASK_EN
        .ch_mask(ch_mask),
`endif
        .out(out), .out_ch(out_ch), .out_valid(out_valid), .sel_err(sel_err)
    );

    mux_nx1_scan #(.WIDTH(8), .N_CH(3), .DWELL(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_bus(in_bus3), .en(en3), .mode(mode3), .sel(sel3),
        .out_ready(out_ready3),
`ifdef MUX_SCAN_MASK_EN
        .ch_mask(ch_mask3),
`endif
        .out(out3), .out_ch(out_ch3), .out_valid(out_valid3), .sel_err(sel_err3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++; if (out !== 8'h00) begin errors++; $display("FAIL reset_out got %0h exp 0", out); end
        checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL reset_out_ch got %0d exp 0", out_ch); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
        checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err got %0b exp 0", sel_err); end
        checks++; if (out_valid3 !== 1'b0) begin errors++; $display("FAIL reset_valid3 got %0b exp 0", out_valid3); end
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_manual();
        logic [7:0] exp_d;
        en = 1'b1; mode = 1'b0; out_ready = 1'b1; sel = 2'd0;
        step();
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            step();
            exp_d = 8'((i + 1) * 17);
            checks++; if (out !== exp_d) begin errors++; $display("FAIL manual_out sel=%0d got %0h exp %0h", i, out, exp_d); end
            checks++; if (out_ch !== 2'(i)) begin errors++; $display("FAIL manual_out_ch got %0d exp %0d", out_ch, i); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL manual_valid got %0b exp 1", out_valid); end
            checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL manual_sel_err got %0b exp 0", sel_err); end
        end
    endtask

    task automatic test_sel_err();
        en3 = 1'b1; mode3 = 1'b0; out_ready3 = 1'b1; sel3 = 2'd0;
        step();
        sel3 = 2'd3;
        step();
        checks++; if (out3 !== 8'h33) begin errors++; $display("FAIL selerr_out got %0h exp 33", out3); end
        checks++; if (out_ch3 !== 2'd2) begin errors++; $display("FAIL selerr_out_ch got %0d exp 2", out_ch3); end
        checks++; if (sel_err3 !== 1'b1) begin errors++; $display("FAIL selerr_flag got %0b exp 1", sel_err3); end
        sel3 = 2'd1;
        step();
        checks++; if (out3 !== 8'h22) begin errors++; $display("FAIL selerr_clear_out got %0h exp 22", out3); end
        checks++; if (out_ch3 !== 2'd1) begin errors++; $display("FAIL selerr_clear_out_ch got %0d exp 1", out_ch3); end
        checks++; if (sel_err3 !== 1'b0) begin errors++; $display("FAIL selerr_clear got %0b exp 0", sel_err3); end
        en3 = 1'b0;
    endtask

    task automatic test_scan();
        logic [7:0] exp_d;
        logic [1:0] exp_ch;
        mode = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            repeat (3) begin
                step();
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL scan_gap k=%0d got %0b exp 0", k, out_valid); end
            end
            step();
            exp_ch = 2'(k % 4);
            exp_d  = 8'(((k % 4) + 1) * 17);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL scan_valid k=%0d got %0b exp 1", k, out_valid); end
            checks++; if (out_ch !== exp_ch) begin errors++; $display("FAIL scan_out_ch k=%0d got %0d exp %0d", k, out_ch, exp_ch); end
            checks++; if (out !== exp_d) begin errors++; $display("FAIL scan_out k=%0d got %0h exp %0h", k, out, exp_d); end
            checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL scan_sel_err got %0b exp 0", sel_err); end
        end
    endtask

    task automatic test_backpressure();
        repeat (3) step();
        out_ready = 1'b0;
        step();
        checks++; if (out_ch !== 2'd1 || out !== 8'h22 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_capture got ch=%0d d=%0h v=%0b exp ch=1 d=22 v=1", out_ch, out, out_valid);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (out_ch !== 2'd1 || out !== 8'h22 || out_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hold cyc=%0d got ch=%0d d=%0h v=%0b exp ch=1 d=22 v=1", i, out_ch, out, out_valid);
            end
        end
        out_ready = 1'b1;
        repeat (3) begin
            step();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_gap got %0b exp 0", out_valid); end
        end
        step();
        checks++; if (out_ch !== 2'd2 || out !== 8'h33 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_resume got ch=%0d d=%0h v=%0b exp ch=2 d=33 v=1", out_ch, out, out_valid);
        end
    endtask

    task automatic test_reset_mid_scan();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out !== 8'h00) begin errors++; $display("FAIL midrst_out got %0h exp 0", out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %0b exp 0", out_valid); end
        checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL midrst_out_ch got %0d exp 0", out_ch); end
        step();
        rst_n = 1'b1;
        repeat (4) begin
            step();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_gap got %0b exp 0", out_valid); end
        end
        step();
        checks++; if (out_ch !== 2'd0 || out !== 8'h11 || out_valid !== 1'b1) begin
            errors++; $display("FAIL midrst_restart got ch=%0d d=%0h v=%0b exp ch=0 d=11 v=1", out_ch, out, out_valid);
        end
    endtask

    task automatic test_idle_hold();
        mode = 1'b0; sel = 2'd2; out_ready = 1'b1;
        step();
        step();
        checks++; if (out !== 8'h33 || out_valid !== 1'b1) begin
            errors++; $display("FAIL idle_pre got d=%0h v=%0b exp d=33 v=1", out, out_valid);
        end
        out_ready = 1'b0; en = 1'b0; sel = 2'd0;
        step();
        step();
        checks++; if (out !== 8'h33 || out_valid !== 1'b1) begin
            errors++; $display("FAIL idle_hold got d=%0h v=%0b exp d=33 v=1", out, out_valid);
        end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_accept got %0b exp 0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b0 || out !== 8'h33) begin
            errors++; $display("FAIL idle_no_capture got d=%0h v=%0b exp d=33 v=0", out, out_valid);
        end
    endtask

`ifdef MUX_SCAN_MASK_EN
    task automatic test_mask();
        logic [1:0] exp_seq [4];
        int n;
        int vcnt;
        exp_seq[0] = 2'd1; exp_seq[1] = 2'd3; exp_seq[2] = 2'd1; exp_seq[3] = 2'd3;
        ch_mask = 4'b1010; out_ready = 1'b1; en = 1'b1; mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                step();
                n++;
            end while (!out_valid && n < 30);
            checks++;
            if (!out_valid) begin
                errors++; $display("FAIL mask_timeout k=%0d got no valid exp valid", k);
            end else if (out_ch !== exp_seq[k]) begin
                errors++; $display("FAIL mask_out_ch k=%0d got %0d exp %0d", k, out_ch, exp_seq[k]);
            end
        end
        ch_mask = 4'b0000;
        step();
        vcnt = 0;
        repeat (20) begin
            step();
            if (out_valid) vcnt++;
        end
        checks++; if (vcnt != 0) begin errors++; $display("FAIL mask_all_off got %0d valid cycles exp 0", vcnt); end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        in_bus = 32'h44332211; en = 1'b0; mode = 1'b0; sel = 2'd0; out_ready = 1'b1;
        in_bus3 = 24'h332211; en3 = 1'b0; mode3 = 1'b0; sel3 = 2'd0; out_ready3 = 1'b1;
`ifdef MUX_SCAN_MASK_EN
        ch_mask = 4'b1111;
        ch_mask3 = 3'b111;
`endif
        test_reset();
        test_manual();
        test_sel_err();
        test_scan();
        test_backpressure();
        test_reset_mid_scan();
        test_idle_hold();
`ifdef MUX_SCAN_MASK_EN
        test_mask();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
